// File: rtl/dmem_pkg.sv
// Shared types for the data-memory write buffer: entry layout and pointer sizing.
package dmem_pkg;

  // Entries hold a full 30-bit word address; instances compare only the zero-extended AW bits they use.
  localparam int WBUF_AW_MAX = 30;
  localparam int WBUF_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [WBUF_AW_MAX-1:0] addr;
    logic [31:0]            data;
  } wbuf_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int WBUF_PTR_W = ptr_width(WBUF_DEPTH_DEFAULT);

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store buffer: pointers, occupancy, entry storage and a youngest-match lookup.
// Lookup, merge and forwarding always use the pre-edge contents.
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  localparam int PW   = ptr_width(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          merge,
  input  logic [AW-1:0] push_addr,
  input  logic [31:0]   push_data,
  input  logic [AW-1:0] look_addr,
  output logic          hit,
  output logic [31:0]   hit_data,
  output logic [AW-1:0] head_addr,
  output logic [31:0]   retire_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wbuf_entry_t   entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] scan_idx;
  logic          merge_wr;
  logic          alloc;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Walk oldest to youngest so the last matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PW'(k);
      if ((CW'(k) < count) && (entries[scan_idx].addr == WBUF_AW_MAX'(look_addr))) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign hit_data  = entries[hit_idx].data;
  assign head_addr = entries[head].addr[AW-1:0];
  assign merge_wr  = push && merge && hit;
  assign alloc     = push && !merge_wr;

  // A merge into the head that retires on the same edge must carry the new data out.
  assign retire_data = (merge_wr && (hit_idx == head)) ? push_data : entries[head].data;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc) tail <= tail + 1'b1;
      if (pop)   head <= head + 1'b1;
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (merge_wr) entries[hit_idx].data <= push_data;
      if (alloc)    entries[tail] <= '{addr: WBUF_AW_MAX'(push_addr), data: push_data};
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Data memory with a posted write buffer and store-to-load forwarding.
// Optional DMEM_WBUF_MERGE_EN folds stores to an already-buffered word into that entry.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int    DEPTH     = 4,
  parameter int    AW        = 6,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              a,
  input  logic [31:0]              wd,
  output logic [31:0]              rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] word;
  logic          retire;
  logic          merge;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [AW-1:0] head_addr;
  logic [31:0]   retire_data;
  logic          unused_addr_bits;

  assign word             = a[AW+1:2];
  assign unused_addr_bits = ^{a[31:AW+2], a[1:0]};

`ifdef DMEM_WBUF_MERGE_EN
  assign merge = 1'b1;
`else
  assign merge = 1'b0;
`endif

  // Drain on store-free cycles; a store into a full buffer forces one retire.
  assign retire = memwrite ? full : !empty;

  wbuf_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (memwrite),
    .pop         (retire),
    .merge       (merge),
    .push_addr   (word),
    .push_data   (wd),
    .look_addr   (word),
    .hit         (fwd_hit),
    .hit_data    (fwd_data),
    .head_addr   (head_addr),
    .retire_data (retire_data),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset && retire) mem[head_addr] <= retire_data;
  end

  assign rd = fwd_hit ? fwd_data : mem[word];

endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf (DEPTH=4, AW=6) with a queue-based reference model.
module tb_dmem_wbuf;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mbuf [$];
  logic [31:0] mmem [64];
  bit          mknown [64];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  logic [31:0] last_count;
  int          n_checks;
  int          n_fail;

  dmem_wbuf #(.DEPTH(DEPTH), .AW(6), .INIT_FILE("")) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .a        (a),
    .wd       (wd),
    .rd       (rd),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model
  task automatic retire_one();
    ent_t e;
    e = mbuf.pop_front();
    mmem[e.addr]   = e.data;
    mknown[e.addr] = 1'b1;
  endtask

  task automatic model_load(input logic [5:0] w, output logic [31:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    for (int i = mbuf.size() - 1; i >= 0; i--) begin
      if (mbuf[i].addr == w) begin
        v  = mbuf[i].data;
        ok = 1'b1;
        break;
      end
    end
    if (!ok && mknown[w]) begin
      v  = mmem[w];
      ok = 1'b1;
    end
  endtask

  task automatic model_edge(input bit we, input logic [5:0] w, input logic [31:0] data);
    bit merged;
    merged = 1'b0;
    if (we) begin
`ifdef DMEM_WBUF_MERGE_EN
      for (int i = mbuf.size() - 1; i >= 0; i--) begin
        if (mbuf[i].addr == w) begin
          mbuf[i].data = data;
          merged = 1'b1;
          break;
        end
      end
`endif
      if (mbuf.size() == DEPTH) retire_one();
      if (!merged) mbuf.push_back('{addr: w, data: data});
    end else if (mbuf.size() > 0) begin
      retire_one();
    end
  endtask

  // Drivers
  task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] v;
    bit          ok;
    logic [5:0]  w;
    w = addr[7:2];
    @(negedge clk);
    memwrite = we;
    a        = addr;
    wd       = data;
    model_load(w, v, ok);
    if (ok) exp_q.push_back(v);
    #1;
    last_rd = rd;
    if (ok) check("rd", rd, exp_q.pop_front());
    @(posedge clk);
    model_edge(we, w, data);
    exp_q.push_back(32'(mbuf.size()));
    #1;
    last_count = 32'(count);
    check("count", 32'(count), exp_q.pop_front());
    check("full", 32'(full), 32'(mbuf.size() == DEPTH));
    check("empty", 32'(empty), 32'(mbuf.size() == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    memwrite = 1'b0;
    @(posedge clk);
    mbuf.delete();
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    memwrite = 1'b0;
    a        = '0;
    wd       = '0;
    repeat (3) @(posedge clk);
    do_reset();

    // Make every RAM word known, then drain.
    for (int w = 0; w < 64; w++) step(1'b1, 32'(w) << 2, $urandom);
    repeat (4) step(1'b0, 32'h0, 32'h0);

    // Reset leaves RAM intact; idle cycles and a full read sweep.
    do_reset();
    repeat (3) step(1'b0, 32'h0, 32'h0);
    for (int w = 0; w < 64; w++) step(1'b0, 32'(w) << 2, 32'h0);

    // Store then forward next cycle, then read back from RAM.
    step(1'b1, 32'h54, 32'd7);
    step(1'b0, 32'h54, 32'h0);
    check("fwd7", last_rd, 32'd7);
    check("fwd7_count", last_count, 32'd0);
    step(1'b0, 32'h54, 32'h0);
    check("ram21", last_rd, 32'd7);

    // Fill, then forced retire on a store into a full buffer.
    step(1'b1, 32'h20, 32'hA0);
    step(1'b1, 32'h1C, 32'hA1);
    step(1'b1, 32'h18, 32'hA2);
    step(1'b1, 32'h34, 32'hA3);
    check("fill_full", 32'(full), 32'd1);
    step(1'b1, 32'h14, 32'd28);
    check("force_count", last_count, 32'd4);
    step(1'b0, 32'h14, 32'h0);
    check("fwd28", last_rd, 32'd28);
    step(1'b0, 32'h20, 32'h0);
    check("retired20", last_rd, 32'hA0);
    repeat (3) step(1'b0, 32'h0, 32'h0);

    // Duplicate addresses: youngest wins.
    step(1'b1, 32'h40, 32'd1);
    step(1'b1, 32'h40, 32'd2);
`ifdef DMEM_WBUF_MERGE_EN
    check("dup_count", last_count, 32'd1);
`else
    check("dup_count", last_count, 32'd2);
`endif
    step(1'b0, 32'h40, 32'h0);
    check("dup_rd", last_rd, 32'd2);
    repeat (2) step(1'b0, 32'h0, 32'h0);

    // Reset with stores pending discards them.
    step(1'b1, 32'h60, 32'hDEAD0001);
    step(1'b1, 32'h64, 32'hDEAD0002);
    step(1'b1, 32'h68, 32'hDEAD0003);
    do_reset();
    step(1'b0, 32'h60, 32'h0);
    step(1'b0, 32'h64, 32'h0);
    step(1'b0, 32'h68, 32'h0);

    // Drain sequence 3,2,1,0 and readback in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h80 + 32'(i) * 4, 32'hC0 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0);
      check("drain_count", last_count, 32'(3 - i));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h80 + 32'(i) * 4, 32'h0);
      check("drain_ram", last_rd, 32'hC0 + 32'(i));
    end

    // Address aliasing by truncation.
    step(1'b1, 32'h154, 32'd99);
    step(1'b0, 32'h54, 32'h0);
    check("alias", last_rd, 32'd99);

    // Random traffic over a small address set to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      ra = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), ra, $urandom);
    end
    repeat (5) step(1'b0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
